// File: rtl/piano_pkg.sv
// Shared pitch table, voice operation codes and width helpers for the piano core.
// Pure definitions: no state, no latency.
// No flow control; consumed by poly_piano_core and poly_voice.
package piano_pkg;

  // What a voice does on the coming edge.
  typedef enum logic [1:0] {
    VOP_HOLD    = 2'd0,  // idle and not chosen
    VOP_LOAD    = 2'd1,  // idle and takes a new key
    VOP_RELEASE = 2'd2,  // owned key went up: return to idle
    VOP_RUN     = 2'd3   // owned key still down: keep counting
  } voice_op_e;

  // Half-period in 10 MHz cycles at octave 0, key 0 = C .. 11 = B.
  // Out-of-range keys return 0, which lands in the silent div < 2 case.
  function automatic logic [31:0] base_div(input int key);
    case (key)
      0:       return 32'd305810;
      1:       return 32'd288648;
      2:       return 32'd272479;
      3:       return 32'd257194;
      4:       return 32'd242718;
      5:       return 32'd229095;
      6:       return 32'd216226;
      7:       return 32'd204082;
      8:       return 32'd192604;
      9:       return 32'd181818;
      10:      return 32'd171613;
      11:      return 32'd161970;
      default: return 32'd0;
    endcase
  endfunction

  // Bits needed to hold a key index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to count 0..voices sounding voices.
  function automatic int mix_w(input int voices);
    return $clog2(voices + 1);
  endfunction

endpackage

// File: rtl/poly_voice.sv
// One square-wave voice: owns a key, divides the clock by the key's half-period.
// Load/release take effect on the next edge; tone toggles div cycles after load.
// No backpressure; a voice accepts a load only while idle.
module poly_voice
  import piano_pkg::*;
#(
  parameter int NUM_KEYS = 12,
  parameter int DIV_W    = 20,
  parameter int OCT_W    = 4,
  parameter int KIW      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_vld,
  input  logic [KIW-1:0]      alloc_key,
  input  logic [NUM_KEYS-1:0] keys_q,
  input  logic [OCT_W-1:0]    octave_q,
  output logic                active,
  output logic [KIW-1:0]      key,
  output logic                tone
);

  logic             active_q, active_d;
  logic [KIW-1:0]   key_q, key_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tone_q, tone_d;
  logic [DIV_W-1:0] div;
  logic             held;
  voice_op_e        op;

  // Half-period follows the live octave every cycle; check our key is still down.
  always_comb begin
    div  = DIV_W'(base_div(int'(key_q))) >> octave_q;
    held = 1'b0;
    if (int'(key_q) < NUM_KEYS) held = keys_q[key_q];
  end

  // Classify this cycle's action for the voice.
  always_comb begin
    if (!active_q)  op = alloc_vld ? VOP_LOAD : VOP_HOLD;
    else if (!held) op = VOP_RELEASE;
    else            op = VOP_RUN;
  end

  // Counter/tone update; >= compare lets an octave jump fire on the next edge.
  always_comb begin
    active_d = active_q;
    key_d    = key_q;
    cnt_d    = cnt_q;
    tone_d   = tone_q;
    case (op)
      VOP_LOAD: begin
        active_d = 1'b1;
        key_d    = alloc_key;
        cnt_d    = '0;
        tone_d   = 1'b0;
      end
      VOP_RELEASE: begin
        active_d = 1'b0;
        key_d    = '0;
        cnt_d    = '0;
        tone_d   = 1'b0;
      end
      VOP_RUN: begin
        if (div < DIV_W'(2)) begin
          cnt_d  = '0;
          tone_d = 1'b0;
        end else if (cnt_q >= div - DIV_W'(1)) begin
          cnt_d  = '0;
          tone_d = ~tone_q;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Voice state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      key_q    <= '0;
      cnt_q    <= '0;
      tone_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      key_q    <= key_d;
      cnt_q    <= cnt_d;
      tone_q   <= tone_d;
    end
  end

  assign active = active_q;
  assign key    = key_q;
  assign tone   = tone_q;

endmodule

// File: rtl/poly_piano_core.sv
// Polyphonic piano: registered keys, stable lowest-free-voice allocation, tone mix.
// Key press to voice_active is 2 edges; at most one key allocated per cycle.
// No stealing: an unserved key raises dropped and waits for a voice to free.
module poly_piano_core
  import piano_pkg::*;
#(
  parameter  int NUM_KEYS = 12,
  parameter  int VOICES   = 4,
  parameter  int DIV_W    = 20,
  parameter  int OCT_W    = 4,
  localparam int KIW      = idx_w(NUM_KEYS),
  localparam int MIX_W    = mix_w(VOICES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_KEYS-1:0]   keys_in,
  input  logic [OCT_W-1:0]      octave,
  output logic [VOICES-1:0]     voice_tone,
  output logic [VOICES-1:0]     voice_active,
  output logic [VOICES*KIW-1:0] voice_key,
  output logic [MIX_W-1:0]      mix_out,
  output logic                  dropped
);

  logic [NUM_KEYS-1:0] keys_q, keys_d;
  logic [OCT_W-1:0]    octave_q, octave_d;
  logic                dropped_q, dropped_d;

  logic [NUM_KEYS-1:0] owned, cand, cand_oh;
  logic [VOICES-1:0]   act, tone, free, free_oh, alloc_vld;
  logic [KIW-1:0]      vkey [VOICES];
  logic [KIW-1:0]      alloc_key;
  logic [MIX_W-1:0]    mix;

  // Input stage: raw levels are captured as-is, no debouncing.
  always_comb begin
    keys_d   = keys_in;
    octave_d = octave;
  end

  // Lowest unowned pressed key goes to the lowest idle voice; a voice
  // releasing this cycle is still active here, so it is reused only next cycle.
  always_comb begin
    owned = '0;
    for (int v = 0; v < VOICES; v++) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (act[v] && (vkey[v] == KIW'(k))) owned[k] = 1'b1;
      end
    end
    cand    = keys_q & ~owned;
    cand_oh = cand & (~cand + NUM_KEYS'(1));
    free    = ~act;
    free_oh = free & (~free + VOICES'(1));
    alloc_key = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (cand_oh[k]) alloc_key = KIW'(k);
    end
    alloc_vld = (|cand) ? free_oh : '0;
    dropped_d = (|cand) && !(|free);
  end

  // Mix level from the registered tones; en gates outputs only.
  always_comb begin
    mix = '0;
    for (int v = 0; v < VOICES; v++) begin
      mix = mix + MIX_W'(tone[v] & act[v]);
    end
    voice_tone = tone & {VOICES{en}};
    mix_out    = en ? mix : '0;
  end

  // Shared input and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      keys_q    <= '0;
      octave_q  <= '0;
      dropped_q <= 1'b0;
    end else begin
      keys_q    <= keys_d;
      octave_q  <= octave_d;
      dropped_q <= dropped_d;
    end
  end

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    poly_voice #(
      .NUM_KEYS (NUM_KEYS),
      .DIV_W    (DIV_W),
      .OCT_W    (OCT_W),
      .KIW      (KIW)
    ) u_voice (
      .clk       (clk),
      .rst       (rst),
      .alloc_vld (alloc_vld[v]),
      .alloc_key (alloc_key),
      .keys_q    (keys_q),
      .octave_q  (octave_q),
      .active    (act[v]),
      .key       (vkey[v]),
      .tone      (tone[v])
    );
    assign voice_key[v*KIW +: KIW] = vkey[v];
  end

  assign voice_active = act;
  assign dropped      = dropped_q;

endmodule

// File: tb/tb_poly_piano_core.sv
// Bench for poly_piano_core: vector table, hand sequences for timing corners,
// and randomized key/octave/en/rst traffic checked against a reference model.
module tb_poly_piano_core;

  localparam int NK  = 12;
  localparam int NV  = 4;
  localparam int KIW = 4;
  localparam int MW  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en  = 1'b1;
  logic [NK-1:0]   keys_in = '0;
  logic [3:0]      octave  = '0;
  logic [NV-1:0]   voice_tone, voice_active;
  logic [NV*KIW-1:0] voice_key;
  logic [MW-1:0]   mix_out;
  logic            dropped;

  int checks = 0;
  int errors = 0;

  poly_piano_core dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .keys_in      (keys_in),
    .octave       (octave),
    .voice_tone   (voice_tone),
    .voice_active (voice_active),
    .voice_key    (voice_key),
    .mix_out      (mix_out),
    .dropped      (dropped)
  );

  always #50 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Keys are owned by voice slots (-1 = free); each sounding voice tracks
  // cycles since its last toggle and flips once that reaches the half-period.
  int base [NK] = '{305810, 288648, 272479, 257194, 242718, 229095,
                    216226, 204082, 192604, 181818, 171613, 161970};
  logic [NK-1:0] m_keys = '0;
  int  m_oct = 0;
  int  m_own  [NV] = '{-1, -1, -1, -1};
  int  m_since[NV] = '{0, 0, 0, 0};
  bit  m_tone [NV] = '{0, 0, 0, 0};
  bit  m_drop = 0;
  bit  model_on = 0;

  function automatic bit is_owned(input int k);
    for (int v = 0; v < NV; v++) if (m_own[v] == k) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_update();
    int cand, slot, half;
    if (rst) begin
      m_keys = '0;
      m_oct  = 0;
      m_drop = 0;
      for (int v = 0; v < NV; v++) begin
        m_own[v] = -1; m_since[v] = 0; m_tone[v] = 0;
      end
      return;
    end
    cand = -1;
    for (int k = 0; k < NK; k++) if (cand < 0 && m_keys[k] && !is_owned(k)) cand = k;
    slot = -1;
    for (int v = 0; v < NV; v++) if (slot < 0 && m_own[v] < 0) slot = v;
    m_drop = (cand >= 0) && (slot < 0);
    for (int v = 0; v < NV; v++) begin
      if (m_own[v] >= 0) begin
        if (!m_keys[m_own[v]]) begin
          m_own[v] = -1; m_since[v] = 0; m_tone[v] = 0;
        end else begin
          half = base[m_own[v]] >> m_oct;
          if (half < 2) begin
            m_since[v] = 0; m_tone[v] = 0;
          end else if (m_since[v] + 1 >= half) begin
            m_since[v] = 0; m_tone[v] = !m_tone[v];
          end else begin
            m_since[v] = m_since[v] + 1;
          end
        end
      end
    end
    if (cand >= 0 && slot >= 0) begin
      m_own[slot] = cand; m_since[slot] = 0; m_tone[slot] = 0;
    end
    m_keys = keys_in;
    m_oct  = int'(octave);
  endtask

  task automatic model_compare();
    logic [NV-1:0]     ea, et;
    logic [NV*KIW-1:0] ek;
    int mix;
    mix = 0;
    for (int v = 0; v < NV; v++) begin
      ea[v] = (m_own[v] >= 0);
      ek[v*KIW +: KIW] = ea[v] ? KIW'(m_own[v]) : '0;
      et[v] = en && ea[v] && m_tone[v];
      if (et[v]) mix++;
    end
    check("model_active", voice_active, ea);
    check("model_key", voice_key, ek);
    check("model_tone", voice_tone, et);
    check("model_mix", mix_out, mix);
    check("model_dropped", dropped, m_drop);
  endtask

  // One clock: model samples with the DUT, outputs compared at the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_update();
    @(negedge clk);
    if (model_on) model_compare();
  endtask

  task automatic do_reset();
    keys_in = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic wait_tone(input int v, input logic lvl, input int budget, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (voice_tone[v] !== lvl && n < budget);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NK-1:0] keys;
    int            ncyc;
    logic [NV-1:0] act;
    logic [15:0]   vk;
    logic          drop;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int n;
    tbl[0]  = '{12'h000, 3, 4'h0, 16'h0000, 1'b0};
    tbl[1]  = '{12'h091, 2, 4'h1, 16'h0000, 1'b0};
    tbl[2]  = '{12'h091, 1, 4'h3, 16'h0040, 1'b0};
    tbl[3]  = '{12'h091, 1, 4'h7, 16'h0740, 1'b0};
    tbl[4]  = '{12'h091, 3, 4'h7, 16'h0740, 1'b0};
    tbl[5]  = '{12'h000, 2, 4'h0, 16'h0000, 1'b0};
    tbl[6]  = '{12'h0B5, 2, 4'h1, 16'h0000, 1'b0};
    tbl[7]  = '{12'h0B5, 1, 4'h3, 16'h0020, 1'b0};
    tbl[8]  = '{12'h0B5, 1, 4'h7, 16'h0420, 1'b0};
    tbl[9]  = '{12'h0B5, 1, 4'hF, 16'h5420, 1'b0};
    tbl[10] = '{12'h0B5, 1, 4'hF, 16'h5420, 1'b1};
    tbl[11] = '{12'h0B5, 3, 4'hF, 16'h5420, 1'b1};
    tbl[12] = '{12'h0B1, 2, 4'hD, 16'h5400, 1'b1};
    tbl[13] = '{12'h0B1, 1, 4'hF, 16'h5470, 1'b0};
    tbl[14] = '{12'h000, 2, 4'h0, 16'h0000, 1'b0};

    // Reset state
    rst = 1'b1;
    cyc();
    cyc();
    check("rst_active", voice_active, 0);
    check("rst_key", voice_key, 0);
    check("rst_tone", voice_tone, 0);
    check("rst_mix", mix_out, 0);
    check("rst_dropped", dropped, 0);
    rst = 1'b0;
    model_on = 1'b1;

    // Allocation order, no-steal and release/reuse timing
    octave = 4'd10;
    for (int e = 0; e < 15; e++) begin
      keys_in = tbl[e].keys;
      repeat (tbl[e].ncyc) cyc();
      check($sformatf("vec%0d_active", e), voice_active, tbl[e].act);
      check($sformatf("vec%0d_key", e), voice_key, tbl[e].vk);
      check($sformatf("vec%0d_dropped", e), dropped, tbl[e].drop);
    end

    // Key 9 (A) at octave 4: half-period 11363
    do_reset();
    octave  = 4'd4;
    keys_in = 12'h200;
    cyc();
    cyc();
    check("a4_active", voice_active, 4'h1);
    check("a4_key", voice_key, 16'h0009);
    wait_tone(0, 1'b1, 20000, n);
    check("a4_first_half", n, 11363);
    check("a4_mix_high", mix_out, 1);
    wait_tone(0, 1'b0, 20000, n);
    check("a4_second_half", n, 11363);
    check("a4_mix_low", mix_out, 0);

    // Octave 5 -> 6 with counter past the new half-period
    do_reset();
    octave  = 4'd5;
    keys_in = 12'h001;
    cyc();
    cyc();
    check("oct_active", voice_active, 4'h1);
    repeat (6000) cyc();
    check("oct_tone_before", voice_tone, 4'h0);
    octave = 4'd6;
    wait_tone(0, 1'b1, 100, n);
    check("oct_jump_toggle", n, 2);
    wait_tone(0, 1'b0, 10000, n);
    check("oct_new_half", n, 4778);

    // en gating keeps allocation and phase running
    do_reset();
    octave  = 4'd13;
    keys_in = 12'h003;
    repeat (40) cyc();
    en = 1'b0;
    cyc();
    check("en_tone", voice_tone, 4'h0);
    check("en_mix", mix_out, 0);
    check("en_active", voice_active, 4'h3);
    repeat (37) cyc();
    en = 1'b1;
    repeat (60) cyc();

    // Reset while three voices sound, keys still held
    keys_in = 12'h091;
    octave  = 4'd12;
    do_reset();
    keys_in = 12'h091;
    repeat (5) cyc();
    check("rmid_pre_active", voice_active, 4'h7);
    rst = 1'b1;
    cyc();
    check("rmid_active", voice_active, 4'h0);
    check("rmid_key", voice_key, 16'h0000);
    check("rmid_tone", voice_tone, 4'h0);
    check("rmid_mix", mix_out, 0);
    check("rmid_dropped", dropped, 1'b0);
    rst = 1'b0;
    cyc();
    check("rmid_after1", voice_active, 4'h0);
    cyc();
    check("rmid_after2", voice_active, 4'h1);
    cyc();
    check("rmid_after3", voice_active, 4'h3);
    cyc();
    check("rmid_after4", voice_active, 4'h7);
    check("rmid_after4_key", voice_key, 16'h0740);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) keys_in = keys_in ^ NK'(1 << $urandom_range(0, NK - 1));
      if ($urandom_range(0, 63) == 0) octave = 4'($urandom_range(11, 15));
      if ($urandom_range(0, 49) == 0) en = ~en;
      rst = ($urandom_range(0, 399) == 0);
      cyc();
    end
    rst = 1'b0;
    en  = 1'b1;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/poly_piano_core.md
Name: poly_piano_core

Overview:
- Polyphonic successor to the single-priority-encoder piano: NUM_KEYS key lines, VOICES independent square-wave voices, shared octave shift.
- Stable voice allocation: a held key keeps its voice until released. A new key takes the lowest free voice, with no reshuffle.
- Drives per-voice tones plus a summed mix level for an external PWM/R-2R stage at the top level.

Parameters:
- NUM_KEYS, 12, number of key inputs (key index 0 = C … 11 = B)
- VOICES, 4, number of simultaneous tone voices
- DIV_W, 20, divider/counter width
- OCT_W, 4, octave input width

Ports:
- clk  in  1  system clock (10 MHz nominal)
- rst  in  1  synchronous reset, active-high
- en  in  1  global enable; 0 forces all tones low, voice state kept
- keys_in  in  NUM_KEYS  raw key levels, 1 = pressed
- octave  in  OCT_W  octave shift applied to all voices
- voice_tone  out  VOICES  per-voice square wave
- voice_active  out  VOICES  voice currently owns a key
- voice_key  out  VOICES*KIW  owning key index per voice; KIW = clog2(NUM_KEYS)
- mix_out  out  clog2(VOICES+1)  count of voices with tone high
- dropped  out  1  a pressed key has no voice this cycle

Behaviour:
- Reset:
  - keys_q = 0 and octave_q = 0.
  - All voices idle; counters 0; tones 0.
  - voice_key = 0, mix_out = 0, dropped = 0.
- Input stage: keys_in and octave are registered every cycle (keys_q, octave_q). No debouncing.
- Release:
  - An active voice whose key is 0 in keys_q goes idle on the next edge.
  - Its counter clears and its tone goes to 0.
- Allocation:
  - Candidate keys are set in keys_q and not owned by any active voice.
  - Per cycle, at most one key is allocated: the lowest-index candidate goes to the lowest-index idle voice.
  - Release and allocation occur in the same cycle; a voice freed this cycle is not reusable until the next cycle.
  - When several keys are pressed together, they are allocated one per cycle in ascending key order.
- No voice stealing:
  - If candidates exist and no voice is idle, dropped = 1 (registered, same timing as voice_active).
  - The key is allocated once a voice frees.
- Latency:
  - keys_in rising at edge N-1 setup means keys_q is set at edge N, and voice_active is set at edge N+1.
  - The first tone toggle is div cycles after activation.
- Divider:
  - div = BASE_DIV[key] >> octave_q, recomputed every cycle.
  - The tone toggles when counter == div-1, then the counter clears. Half-period = div cycles.
- div < 2:
  - The voice stays active with tone held 0.
  - octave_q ≥ DIV_W forces this case.
- Octave change mid-note: if counter ≥ new div-1, toggle and clear on the next edge. No glitch longer than one cycle.
- en = 0:
  - voice_tone and mix_out are forced to 0 (output gating only).
  - Counters and allocation continue.
- mix_out = popcount(voice_tone & voice_active), registered with the tones.
- Reset mid-note: all state is cleared on the reset edge regardless of keys. Allocation restarts two cycles after rst falls if keys are held.

Decomposition:
- piano_pkg holds:
  - BASE_DIV[0..11] at octave 0, 10 MHz: 305810, 288648, 272479, 257194, 242718, 229095, 216226, 204082, 192604, 181818, 171613, 161970.
  - The KIW/mix-width helper functions.
- Sub-module poly_voice (counter, toggle, div compare, release clear) is instantiated VOICES times. Allocation logic stays in poly_piano_core.

Test Plan:
- Reset, then press key 9, octave 4 → voice0 active 2 cycles later, voice_key[0] = 9, div = 11363, tone toggles every 11363 cycles, mix_out alternates 0/1.
- Press keys 0, 4, 7 on the same cycle → voices 0/1/2 get keys 0/4/7 on three consecutive cycles, voice 3 stays idle, dropped = 0.
- Five keys {0, 2, 4, 5, 7} held, VOICES = 4 → key 7 unassigned and dropped = 1. Release key 2 → voice1 idles; next cycle voice1 takes key 7 and dropped = 0.
- Hold key 0 on voice0, change octave 2→3 mid-period with counter = 50000 → div goes from 76452 to 38226; toggle on the next edge, then half-period 38226.
- en = 0 while two voices are sounding → voice_tone = 0 and mix_out = 0, voice_active unchanged. Raising en restores tones with phase continuous.
- Assert rst while three voices are active → next edge all outputs 0. Keys still held after rst drops are reallocated in ascending order starting 2 cycles later.
